sysid_ctrl: RTL and testbench

SYSID_CTRL -- requirements
Module: sysid_ctrl

---
 rtl/sysid_ctrl_pkg.sv | 18 +
 rtl/sysid_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sysid_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_ctrl_pkg.sv
// rtl/sysid_ctrl_pkg.sv - shared states, slave addresses and default ID constants for sysid_ctrl
package sysid_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic        SYSID_ADDR_ID = 1'b0;
    localparam logic        SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h4E4D_FF79;

endpackage

// File: rtl/sysid_ctrl.sv
// rtl/sysid_ctrl.sv - system ID checker sharing the sysid slave with a host port (optional SYSID_CTRL_AUTOSTART_EN)
module sysid_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS = SYSID_DEFAULT_TS,
    parameter int          MAX_TRY     = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        host_read,
    input  logic        host_address,
    output logic        host_waitrequest,
    output logic        host_readdatavalid,
    output logic [31:0] host_readdata,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  tries
);

    localparam logic [2:0] MAX_TRY_W = 3'(MAX_TRY);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] id_q;
    logic [31:0] ts_q;
    logic [2:0]  tries_q;
    logic        done_q;
    logic        pass_q;
    logic        rdv_q;
    logic [31:0] rdata_q;

    logic        start_eff;
    logic        idle_like;
    logic        host_accept;
    logic        check_ok;
    logic        launch;
    logic        retry;
    logic        finish;

`ifdef SYSID_CTRL_AUTOSTART_EN
    logic autostart_q;

    // Held high through reset so the first released cycle acts as a start request
    always_ff @(posedge clock) begin
        autostart_q <= !reset_n;
    end

    assign start_eff = start | autostart_q;
`else
    assign start_eff = start;
`endif

    assign idle_like        = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign check_ok         = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
    assign host_accept      = idle_like && !start_eff && host_read;
    assign host_waitrequest = !idle_like || start_eff;

    assign busy               = !idle_like;
    assign done               = done_q;
    assign pass               = pass_q;
    assign tries              = tries_q;
    assign host_readdatavalid = rdv_q;
    assign host_readdata      = rdata_q;

    // Checker owns the slave address while reading; otherwise the host address passes through
    always_comb begin
        sid_address = host_address;
        case (state_q)
            ST_RD_ID: sid_address = SYSID_ADDR_ID;
            ST_RD_TS: sid_address = SYSID_ADDR_TS;
            default:  sid_address = host_address;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the one-cycle control strobes for the datapath
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        retry   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_eff) begin
                    state_d = ST_RD_ID;
                    launch  = 1'b1;
                end
            end
            ST_RD_ID: state_d = ST_RD_TS;
            ST_RD_TS: state_d = ST_CHK;
            ST_CHK: begin
                if (check_ok) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end else if (tries_q < MAX_TRY_W) begin
                    state_d = ST_RD_ID;
                    retry   = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Captured slave words and check status
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            id_q    <= '0;
            ts_q    <= '0;
            tries_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            if (state_q == ST_RD_ID) begin
                id_q <= sid_readdata;
            end
            if (state_q == ST_RD_TS) begin
                ts_q <= sid_readdata;
            end
            if (launch) begin
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
                tries_q <= 3'd1;
            end
            if (retry) begin
                tries_q <= tries_q + 3'd1;
            end
            if (finish) begin
                done_q <= 1'b1;
                pass_q <= check_ok;
            end
        end
    end

    // Host read response: one valid pulse per accepted read, data held until the next one
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdv_q <= host_accept;
            if (host_accept) begin
                rdata_q <= sid_readdata;
            end
        end
    end

endmodule

// File: tb/tb_sysid_ctrl.sv
// tb/tb_sysid_ctrl.sv - randomized self-checking bench for sysid_ctrl
module tb_sysid_ctrl;

    localparam logic [31:0] EXP_ID  = 32'h0000_0000;
    localparam logic [31:0] EXP_TS  = 32'd1313734521;
    localparam int          MAX_TRY = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        host_read;
    logic        host_address;
    logic        host_waitrequest;
    logic        host_readdatavalid;
    logic [31:0] host_readdata;
    logic        sid_address;
    logic [31:0] sid_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  tries;

    logic [31:0] slave_id;
    logic [31:0] slave_ts;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign sid_readdata = sid_address ? slave_ts : slave_id;

    sysid_ctrl #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .MAX_TRY     (MAX_TRY)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .host_read          (host_read),
        .host_address       (host_address),
        .host_waitrequest   (host_waitrequest),
        .host_readdatavalid (host_readdatavalid),
        .host_readdata      (host_readdata),
        .sid_address        (sid_address),
        .sid_readdata       (sid_readdata),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .tries              (tries)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: a static slave either matches on the first try or fails every try
    function automatic int model_tries(input logic [31:0] id, input logic [31:0] ts);
        return (id == EXP_ID && ts == EXP_TS) ? 1 : MAX_TRY;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic run_check(input bit id_ok, input bit ts_ok);
        int cnt;
        int exp_tries;
        slave_id  = id_ok ? EXP_ID : (EXP_ID ^ ($urandom() | 32'h1));
        slave_ts  = ts_ok ? EXP_TS : (($urandom() % 2) ? 32'hDEAD_BEEF : (EXP_TS ^ ($urandom() | 32'h1)));
        exp_tries = model_tries(slave_id, slave_ts);
        start        = 1'b1;
        host_read    = 1'($urandom() % 2);
        host_address = 1'($urandom() % 2);
        #1;
        check("wait_on_start", host_waitrequest, 1);
        tick();
        start = 1'b0;
        cnt   = 1;
        while (done !== 1'b1 && cnt < 40) begin
            check("busy_in_check", busy, 1);
            check("rdv_in_check", host_readdatavalid, 0);
            start        = 1'($urandom() % 2);
            host_read    = 1'($urandom() % 2);
            host_address = 1'($urandom() % 2);
            #1;
            check("wait_in_check", host_waitrequest, 1);
            tick();
            cnt++;
        end
        start     = 1'b0;
        host_read = 1'b0;
        check("done_latency", cnt, 3 * exp_tries + 1);
        check("done", done, 1);
        check("pass", pass, (exp_tries == 1) ? 1 : 0);
        check("tries", tries, exp_tries);
        check("busy_after", busy, 0);
        // a held host read is accepted once the check is over
        host_read    = 1'b1;
        host_address = 1'($urandom() % 2);
        #1;
        check("wait_after_done", host_waitrequest, 0);
        tick();
        host_read = 1'b0;
        check("rdv_after_done", host_readdatavalid, 1);
        check("data_after_done", host_readdata, host_address ? slave_ts : slave_id);
    endtask

    initial begin
        logic [31:0] exp_data;
        logic        exp_rdv;
        logic [31:0] value;

        reset_n      = 1'b0;
        start        = 1'b0;
        host_read    = 1'b0;
        host_address = 1'b0;
        slave_id     = EXP_ID;
        slave_ts     = EXP_TS;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_tries", tries, 0);
        check("rst_rdv", host_readdatavalid, 0);
        check("rst_rdata", host_readdata, 0);

        reset_n = 1'b1;
`ifdef SYSID_CTRL_AUTOSTART_EN
        wait_done("autostart", 20);
        check("autostart_pass", pass, 1);
        check("autostart_tries", tries, 1);
`else
        tick();
        tick();
        check("no_autostart_busy", busy, 0);
        check("no_autostart_done", done, 0);
`endif

        // fixed first-try pass and the DEAD_BEEF retry case
        run_check(1'b1, 1'b1);
        slave_id = EXP_ID;
        run_check(1'b1, 1'b0);

        // random host reads in idle, including back-to-back
        exp_data = host_readdata;
        for (int i = 0; i < 40; i++) begin
            host_read    = 1'($urandom() % 2);
            host_address = 1'($urandom() % 2);
            slave_id     = $urandom();
            slave_ts     = $urandom();
            value        = host_address ? slave_ts : slave_id;
            exp_rdv      = host_read;
            #1;
            check("host_wait_idle", host_waitrequest, 0);
            check("sid_addr_follow", sid_address, host_address);
            tick();
            if (exp_rdv) exp_data = value;
            check("host_rdv", host_readdatavalid, exp_rdv);
            check("host_rdata", host_readdata, exp_data);
        end
        host_read = 1'b0;

        // timestamp read with the real slave contents
        slave_id     = EXP_ID;
        slave_ts     = EXP_TS;
        host_read    = 1'b1;
        host_address = 1'b1;
        #1;
        check("ts_read_wait", host_waitrequest, 0);
        tick();
        host_read = 1'b0;
        check("ts_read_rdv", host_readdatavalid, 1);
        check("ts_read_data", host_readdata, EXP_TS);
        tick();
        check("ts_read_rdv_once", host_readdatavalid, 0);
        check("ts_read_hold", host_readdata, EXP_TS);

        // random check outcomes
        for (int i = 0; i < 8; i++) begin
            run_check(1'($urandom() % 2), 1'($urandom() % 2));
        end

        // simultaneous start and host read: the checker wins
        slave_id  = EXP_ID;
        slave_ts  = EXP_TS;
        start     = 1'b1;
        host_read = 1'b1;
        #1;
        check("simul_wait", host_waitrequest, 1);
        tick();
        start     = 1'b0;
        host_read = 1'b0;
        check("simul_rdv", host_readdatavalid, 0);
        check("simul_busy", busy, 1);
        wait_done("simul", 20);
        check("simul_pass", pass, 1);

        // reset during RD_TS aborts everything
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_tries", tries, 0);
        check("midrst_rdv", host_readdatavalid, 0);
        check("midrst_rdata", host_readdata, 0);
        reset_n = 1'b1;
`ifdef SYSID_CTRL_AUTOSTART_EN
        wait_done("autostart2", 20);
        check("autostart2_pass", pass, 1);
`else
        tick();
        check("after_rst_idle", busy, 0);
`endif

        // a host read coinciding with reset is dropped
        host_read    = 1'b1;
        host_address = 1'b1;
        reset_n      = 1'b0;
        tick();
        host_read = 1'b0;
        check("rst_drop_rdv", host_readdatavalid, 0);
        check("rst_drop_rdata", host_readdata, 0);
        reset_n = 1'b1;
        tick();
        check("rst_drop_rdv2", host_readdatavalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
